// File: rtl/sbox_layer_iter.sv
// rtl/sbox_layer_iter.sv - iterative forward/inverse ASCON S-box layer, COLS_PER_CYCLE columns per clock
module sbox_layer_iter #(
    parameter int COLS_PER_CYCLE = 8
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             inverse_i,
    input  logic [0:4][63:0] state_i,
    output logic [0:4][63:0] state_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int NB_STEPS = 64 / COLS_PER_CYCLE;
    localparam int STEP_W   = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NB_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_e;

    fsm_e              r_fsm;
    logic [STEP_W-1:0] r_step;
    logic              r_mode;
    logic [0:4][63:0]  r_state;
    logic              r_busy;
    logic              r_done;
    logic [0:4][63:0]  w_next;

    function automatic logic [4:0] sbox5(input logic [4:0] v, input logic inv);
        logic [4:0] y;
        y = 5'h00;
        if (!inv) begin
            case (v)
                5'h00: y = 5'h04; 5'h01: y = 5'h0B; 5'h02: y = 5'h1F; 5'h03: y = 5'h14;
                5'h04: y = 5'h1A; 5'h05: y = 5'h15; 5'h06: y = 5'h09; 5'h07: y = 5'h02;
                5'h08: y = 5'h1B; 5'h09: y = 5'h05; 5'h0A: y = 5'h08; 5'h0B: y = 5'h12;
                5'h0C: y = 5'h1D; 5'h0D: y = 5'h03; 5'h0E: y = 5'h06; 5'h0F: y = 5'h1C;
                5'h10: y = 5'h1E; 5'h11: y = 5'h13; 5'h12: y = 5'h07; 5'h13: y = 5'h0E;
                5'h14: y = 5'h00; 5'h15: y = 5'h0D; 5'h16: y = 5'h11; 5'h17: y = 5'h18;
                5'h18: y = 5'h10; 5'h19: y = 5'h0C; 5'h1A: y = 5'h01; 5'h1B: y = 5'h19;
                5'h1C: y = 5'h16; 5'h1D: y = 5'h0A; 5'h1E: y = 5'h0F; 5'h1F: y = 5'h17;
                default: y = 5'h00;
            endcase
        end else begin
            case (v)
                5'h00: y = 5'h14; 5'h01: y = 5'h1A; 5'h02: y = 5'h07; 5'h03: y = 5'h0D;
                5'h04: y = 5'h00; 5'h05: y = 5'h09; 5'h06: y = 5'h0E; 5'h07: y = 5'h12;
                5'h08: y = 5'h0A; 5'h09: y = 5'h06; 5'h0A: y = 5'h1D; 5'h0B: y = 5'h01;
                5'h0C: y = 5'h19; 5'h0D: y = 5'h15; 5'h0E: y = 5'h13; 5'h0F: y = 5'h1E;
                5'h10: y = 5'h18; 5'h11: y = 5'h16; 5'h12: y = 5'h0B; 5'h13: y = 5'h11;
                5'h14: y = 5'h03; 5'h15: y = 5'h05; 5'h16: y = 5'h1C; 5'h17: y = 5'h1F;
                5'h18: y = 5'h17; 5'h19: y = 5'h1B; 5'h1A: y = 5'h04; 5'h1B: y = 5'h08;
                5'h1C: y = 5'h0F; 5'h1D: y = 5'h0C; 5'h1E: y = 5'h10; 5'h1F: y = 5'h02;
                default: y = 5'h00;
            endcase
        end
        return y;
    endfunction

    // Every column has its own S-box; only the group selected by r_step is written back.
    always_comb begin
        w_next = r_state;
        for (int j = 0; j < 64; j++) begin
            if (STEP_W'(j / COLS_PER_CYCLE) == r_step) begin
                {w_next[0][j], w_next[1][j], w_next[2][j], w_next[3][j], w_next[4][j]} =
                    sbox5({r_state[0][j], r_state[1][j], r_state[2][j],
                           r_state[3][j], r_state[4][j]}, r_mode);
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_fsm   <= S_IDLE;
            r_step  <= '0;
            r_mode  <= 1'b0;
            r_state <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_state <= state_i;
                        r_mode  <= inverse_i;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_fsm   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_state <= w_next;
                    // Counter parks on the last step; it is cleared again on the next start.
                    if (r_step == LAST_STEP) begin
                        r_fsm  <= S_DONE;
                        r_done <= 1'b1;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_fsm  <= S_IDLE;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_fsm  <= S_IDLE;
                end
            endcase
        end
    end

    assign state_o = r_state;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_sbox_layer_iter.sv
// tb/tb_sbox_layer_iter.sv - self-checking bench for sbox_layer_iter at 1, 8 and 64 columns per cycle
module tb_sbox_layer_iter;

    typedef logic [0:4][63:0] state_t;

    typedef struct {
        string  name;
        logic   inv;
        state_t s;
        state_t exp;
    } vec_t;

    localparam logic [4:0] FWD [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
    localparam logic [4:0] INV [32] = '{
        5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
        5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
        5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
        5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02};

    logic   clk = 1'b0;
    logic   rstn;
    logic   start [3];
    logic   inv   [3];
    state_t sin   [3];
    state_t sout  [3];
    logic   busy  [3];
    logic   done  [3];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sbox_layer_iter #(.COLS_PER_CYCLE(1)) u_c1 (
        .clock_i(clk), .resetb_i(rstn), .start_i(start[0]), .inverse_i(inv[0]),
        .state_i(sin[0]), .state_o(sout[0]), .busy_o(busy[0]), .done_o(done[0]));
    sbox_layer_iter #(.COLS_PER_CYCLE(8)) u_c8 (
        .clock_i(clk), .resetb_i(rstn), .start_i(start[1]), .inverse_i(inv[1]),
        .state_i(sin[1]), .state_o(sout[1]), .busy_o(busy[1]), .done_o(done[1]));
    sbox_layer_iter #(.COLS_PER_CYCLE(64)) u_c64 (
        .clock_i(clk), .resetb_i(rstn), .start_i(start[2]), .inverse_i(inv[2]),
        .state_i(sin[2]), .state_o(sout[2]), .busy_o(busy[2]), .done_o(done[2]));

    function automatic state_t model(input state_t s, input logic iv);
        state_t     r;
        logic [4:0] c;
        logic [4:0] y;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            c = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            y = iv ? INV[c] : FWD[c];
            {r[0][j], r[1][j], r[2][j], r[3][j], r[4][j]} = y;
        end
        return r;
    endfunction

    function automatic state_t fill(input logic [4:0] v);
        state_t r;
        for (int w = 0; w < 5; w++) r[w] = {64{v[4-w]}};
        return r;
    endfunction

    function automatic state_t rnd_state();
        state_t r;
        for (int w = 0; w < 5; w++) r[w] = {$urandom(), $urandom()};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int k, input logic iv, input state_t s,
                          output state_t res, output int lat);
        @(negedge clk);
        start[k] = 1'b1;
        inv[k]   = iv;
        sin[k]   = s;
        @(posedge clk); #1;
        start[k] = 1'b0;
        inv[k]   = ~iv;
        sin[k]   = '0;
        lat = 0;
        while (!done[k] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = sout[k];
        @(posedge clk); #1;
    endtask

    vec_t   vecs [$];
    vec_t   v;
    state_t s;
    state_t res;
    state_t res2;
    int     lat;
    int     nb;
    int     nd;
    int     dcyc [$];

    initial begin
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            inv[k]   = 1'b0;
            sin[k]   = '0;
        end
        rstn = 1'b0;

        v.name = "fwd_zero";  v.inv = 1'b0; v.s = '0;
        v.exp = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        vecs.push_back(v);
        v.name = "inv_zero";  v.inv = 1'b1; v.s = '0;
        v.exp = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        vecs.push_back(v);
        v.name = "inv_1f";    v.inv = 1'b1;
        v.s   = {{64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}};
        v.exp = {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs.push_back(v);
        v.name = "fwd_mixed"; v.inv = 1'b0;
        v.s = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_0F0F_F0F0,
               64'h0000_FFFF_0000_FFFF, 64'h1357_9BDF_2468_ACE0};
        v.exp = model(v.s, 1'b0);
        vecs.push_back(v);
        for (int i = 0; i < 32; i++) begin
            v.name = $sformatf("inv_sweep_%0d", i); v.inv = 1'b1;
            v.s = fill(5'(i)); v.exp = fill(INV[i]);
            vecs.push_back(v);
            v.name = $sformatf("fwd_sweep_%0d", i); v.inv = 1'b0;
            v.s = fill(5'(i)); v.exp = fill(FWD[i]);
            vecs.push_back(v);
        end

        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("reset_state", sout[1], '0);
            chk("reset_flags", {busy[1], done[1]}, '0);
        end
        @(negedge clk);
        rstn = 1'b1;

        // Busy/done shape of a single C=8 run.
        @(negedge clk);
        start[1] = 1'b1; inv[1] = 1'b0; sin[1] = '0;
        nb = 0; nd = 0;
        @(posedge clk); #1;
        start[1] = 1'b0;
        while (busy[1] && nb < 50) begin
            nb++;
            if (done[1]) begin
                nd++;
                chk("busy_done_latency", 320'(nb - 1), 320'd8);
            end
            @(posedge clk); #1;
        end
        chk("busy_cycles", 320'(nb), 320'd9);
        chk("done_pulses", 320'(nd), 320'd1);

        foreach (vecs[i]) begin
            run_op(1, vecs[i].inv, vecs[i].s, res, lat);
            chk(vecs[i].name, res, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, 320'(lat), 320'd8);
        end

        for (int k = 0; k < 3; k++) begin
            for (int seed = 0; seed < 100; seed++) begin
                s = rnd_state();
                run_op(k, 1'b0, s, res, lat);
                chk($sformatf("rt_fwd_k%0d", k), res, model(s, 1'b0));
                chk($sformatf("rt_fwd_lat_k%0d", k), 320'(lat), (k == 0) ? 320'd64 : (k == 1) ? 320'd8 : 320'd1);
                run_op(k, 1'b1, res, res2, lat);
                chk($sformatf("rt_back_k%0d", k), res2, s);
            end
        end

        // start_i held high: one accepted start every NB_STEPS+2 cycles.
        @(negedge clk);
        start[1] = 1'b1; inv[1] = 1'b0; sin[1] = fill(5'h03);
        for (int cyc = 0; cyc < 35; cyc++) begin
            @(posedge clk); #1;
            if (done[1]) begin
                dcyc.push_back(cyc);
                chk("held_result", sout[1], fill(5'h14));
            end
        end
        @(negedge clk);
        start[1] = 1'b0;
        chk("held_count", 320'(dcyc.size()), 320'd3);
        if (dcyc.size() == 3) begin
            chk("held_first", 320'(dcyc[0]), 320'd8);
            chk("held_gap1", 320'(dcyc[1] - dcyc[0]), 320'd10);
            chk("held_gap2", 320'(dcyc[2] - dcyc[1]), 320'd10);
        end
        nb = 0;
        while (busy[1] && nb < 50) begin
            @(posedge clk); #1;
            nb++;
        end
        chk("held_drain", {319'd0, busy[1]}, '0);

        // Noise on start/inverse/state during RUN and DONE.
        s = rnd_state();
        @(negedge clk);
        start[1] = 1'b1; inv[1] = 1'b0; sin[1] = s;
        @(posedge clk); #1;
        lat = 0;
        while (!done[1] && lat < 50) begin
            @(negedge clk);
            start[1] = 1'($urandom()); inv[1] = 1'($urandom()); sin[1] = rnd_state();
            @(posedge clk); #1;
            lat++;
        end
        chk("noise_result", sout[1], model(s, 1'b0));
        chk("noise_lat", 320'(lat), 320'd8);
        @(negedge clk);
        start[1] = 1'b1;
        @(posedge clk); #1;
        chk("done_start_not_taken", {318'd0, busy[1], done[1]}, '0);
        chk("done_result_held", sout[1], model(s, 1'b0));
        @(negedge clk);
        start[1] = 1'b0;
        @(posedge clk); #1;
        chk("done_start_not_queued", {318'd0, busy[1], done[1]}, '0);

        // Asynchronous reset in the middle of a run.
        s = rnd_state();
        @(negedge clk);
        start[1] = 1'b1; inv[1] = 1'b1; sin[1] = s;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_state", sout[1], '0);
        chk("async_rst_flags", {318'd0, busy[1], done[1]}, '0);
        nd = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done[1] || busy[1]) nd++;
        end
        chk("rst_no_done", 320'(nd), 320'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_op(1, 1'b1, s, res, lat);
        chk("post_rst_result", res, model(s, 1'b1));
        chk("post_rst_lat", 320'(lat), 320'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
